// File: rtl/ttc_tx_serializer.sv
// ttc_tx_serializer: TTC link transmitter emitting back-to-back MSB-first frames (sync header + 16-bit payload).
// Optional feature macro TTC_TX_PARITY_EN appends an even-parity bit over the payload to every frame.
module ttc_tx_serializer #(
  parameter int unsigned BIT_DIV   = 4,
  parameter logic [3:0]  SYNC_PAT  = 4'b1100,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        clk2x,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        serial_out,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] idle_cnt
);

  localparam int unsigned SYNC_BITS = 4;
  localparam int unsigned DATA_BITS = 16;
`ifdef TTC_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = SYNC_BITS + DATA_BITS + 1;
`else
  localparam int unsigned FRAME_BITS = SYNC_BITS + DATA_BITS;
`endif
  localparam int unsigned DIV_W = 4;
  localparam int unsigned BIT_W = 5;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOAD,
    ST_SYNC,
    ST_DATA,
    ST_PAR
  } state_e;

  state_e                  state_q;
  logic [DIV_W-1:0]        div_cnt_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic                    serial_q;
  logic                    frame_start_q;
  logic                    word_ready_q;
  logic                    busy_q;
  logic [15:0]             idle_cnt_q;

  logic [15:0]             payload_d;
  logic [FRAME_BITS-1:0]   sr_load_d;
  logic [15:0]             idle_cnt_d;
  logic [BIT_W-1:0]        bit_nxt_d;
  state_e                  seg_nxt_d;
  logic                    last_div;
  logic                    pre_last_div;
  logic                    last_bit;

  // Frame image, saturating idle counter and segment of the upcoming bit.
  always_comb begin
    payload_d  = word_valid ? word_in : IDLE_WORD;
`ifdef TTC_TX_PARITY_EN
    sr_load_d  = {SYNC_PAT, payload_d, ^payload_d};
`else
    sr_load_d  = {SYNC_PAT, payload_d};
`endif
    idle_cnt_d = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
    bit_nxt_d  = bit_cnt_q + BIT_W'(1);
    if (bit_nxt_d < BIT_W'(SYNC_BITS)) begin
      seg_nxt_d = ST_SYNC;
    end else if (bit_nxt_d < BIT_W'(SYNC_BITS + DATA_BITS)) begin
      seg_nxt_d = ST_DATA;
    end else begin
      seg_nxt_d = ST_PAR;
    end
  end

  assign last_div     = (div_cnt_q == DIV_W'(BIT_DIV - 1));
  assign pre_last_div = (div_cnt_q == DIV_W'(BIT_DIV - 2));
  assign last_bit     = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));

  // LOAD occupies the final cycle of the previous frame's last bit, so the
  // decision to continue is taken one cycle earlier, on pre_last_div.
  always_ff @(posedge clk2x or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      serial_q      <= 1'b0;
      frame_start_q <= 1'b0;
      word_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      frame_start_q <= 1'b0;
      word_ready_q  <= 1'b0;
      unique case (state_q)
        ST_OFF: begin
          serial_q <= 1'b0;
          if (enable) begin
            state_q      <= ST_LOAD;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_LOAD: begin
          sr_q          <= sr_load_d;
          serial_q      <= sr_load_d[FRAME_BITS-1];
          frame_start_q <= 1'b1;
          div_cnt_q     <= '0;
          bit_cnt_q     <= '0;
          state_q       <= ST_SYNC;
          if (!word_valid) begin
            idle_cnt_q <= idle_cnt_d;
          end
        end
        default: begin
          if (last_div) begin
            div_cnt_q <= '0;
            if (last_bit) begin
              // Only reached when enable was low at the continue decision.
              state_q   <= ST_OFF;
              serial_q  <= 1'b0;
              busy_q    <= 1'b0;
              bit_cnt_q <= '0;
              sr_q      <= '0;
            end else begin
              bit_cnt_q <= bit_nxt_d;
              sr_q      <= sr_q << 1;
              serial_q  <= sr_q[FRAME_BITS-2];
              state_q   <= seg_nxt_d;
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
            if (last_bit && pre_last_div && enable) begin
              state_q      <= ST_LOAD;
              word_ready_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign word_ready  = word_ready_q;
  assign serial_out  = serial_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign idle_cnt    = idle_cnt_q;

endmodule

// File: tb/tb_ttc_tx_serializer.sv
// Directed-vector bench for ttc_tx_serializer: frame content, contiguity, idle count, stop and reset abort.
module tb_ttc_tx_serializer;

  localparam int B = 4;
`ifdef TTC_TX_PARITY_EN
  localparam int F = 21;
`else
  localparam int F = 20;
`endif
  localparam int NM = 9;
  localparam int NT = 10;

  logic        clk2x = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        serial_out;
  logic        frame_start;
  logic        busy;
  logic [15:0] idle_cnt;

  typedef struct {
    logic        valid;
    logic [15:0] word;
    logic [20:0] exp_bits;
    logic [15:0] exp_idle;
  } vec_t;

  vec_t vec [NT];
  int   total = 0;
  int   bad = 0;
  int   idx = 0;
  int   ready_cnt = 0;

  ttc_tx_serializer #(
    .BIT_DIV  (B),
    .SYNC_PAT (4'b1100),
    .IDLE_WORD(16'h0000)
  ) dut (
    .clk2x      (clk2x),
    .rst        (rst),
    .enable     (enable),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .serial_out (serial_out),
    .frame_start(frame_start),
    .busy       (busy),
    .idle_cnt   (idle_cnt)
  );

  always #5 clk2x = ~clk2x;

  always @(negedge clk2x) begin
    if (word_ready === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  // Source: presents vec[idx] and advances after each word_ready cycle.
  initial begin : driver
    logic seen;
    seen       = 1'b0;
    word_valid = 1'b0;
    word_in    = 16'h0000;
    forever begin
      @(negedge clk2x);
      if (seen) idx++;
      if (idx < NT) begin
        word_valid = vec[idx].valid;
        word_in    = vec[idx].word;
      end else begin
        word_valid = 1'b0;
        word_in    = 16'hDEAD;
      end
      seen = (word_ready === 1'b1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(output int waited);
    waited = 0;
    @(negedge clk2x);
    while (frame_start !== 1'b1 && waited < 400) begin
      waited++;
      @(negedge clk2x);
    end
  endtask

  // Called on the negedge where frame_start is seen; checks every cycle of the frame.
  task automatic capture(input logic [20:0] exp_bits, input int drop_at,
                         output logic [31:0] got, output int errs);
    got  = '0;
    errs = 0;
    for (int k = 0; k < F * B; k++) begin
      if (k > 0) @(negedge clk2x);
      if (k == drop_at) enable = 1'b0;
      if (k % B == B / 2) got = {got[30:0], serial_out};
      if (serial_out !== exp_bits[20 - k / B]) errs++;
      if (busy !== 1'b1) errs++;
      if (k > 0 && frame_start !== 1'b0) errs++;
    end
  endtask

  function automatic logic [31:0] exp_frame(input logic [20:0] b);
    return (F == 21) ? 32'(b) : 32'(b[20:1]);
  endfunction

  initial begin : main
    int          w;
    int          errs;
    logic [31:0] got;
    logic [20:0] idle_bits;

    idle_bits = 21'b1100_0000_0000_0000_0000_0;
    vec[0] = '{1'b1, 16'hA5C3, 21'b1100_1010_0101_1100_0011_0, 16'd0};
    vec[1] = '{1'b0, 16'h1234, 21'b1100_0000_0000_0000_0000_0, 16'd1};
    vec[2] = '{1'b0, 16'h5678, 21'b1100_0000_0000_0000_0000_0, 16'd2};
    vec[3] = '{1'b0, 16'h9ABC, 21'b1100_0000_0000_0000_0000_0, 16'd3};
    vec[4] = '{1'b1, 16'h0001, 21'b1100_0000_0000_0000_0001_1, 16'd3};
    vec[5] = '{1'b1, 16'h0002, 21'b1100_0000_0000_0000_0010_1, 16'd3};
    vec[6] = '{1'b1, 16'h0003, 21'b1100_0000_0000_0000_0011_0, 16'd3};
    vec[7] = '{1'b1, 16'h0004, 21'b1100_0000_0000_0000_0100_1, 16'd3};
    vec[8] = '{1'b1, 16'h0007, 21'b1100_0000_0000_0000_0111_1, 16'd3};
    vec[9] = '{1'b1, 16'hFFFF, 21'b1100_1111_1111_1111_1111_0, 16'd3};

    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk2x);
    chk("rst_serial_out", 32'(serial_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_idle_cnt", 32'(idle_cnt), 32'd0);

    rst = 1'b0;
    repeat (4) @(negedge clk2x);
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_word_ready", 32'(word_ready), 32'd0);

    // Streaming: data, three idle frames, four words, then stop mid-frame.
    enable = 1'b1;
    for (int i = 0; i < NM; i++) begin
      wait_fs(w);
      chk($sformatf("gap%0d", i), 32'(w), (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("idle_cnt%0d", i), 32'(idle_cnt), 32'(vec[i].exp_idle));
      capture(vec[i].exp_bits, (i == NM - 1) ? 10 * B : -1, got, errs);
      chk($sformatf("frame_bits%0d", i), got, exp_frame(vec[i].exp_bits));
      chk($sformatf("frame_cycles%0d", i), 32'(errs), 32'd0);
    end

    @(negedge clk2x);
    chk("stop_serial_out", 32'(serial_out), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk2x);
    chk("stop_ready_cnt", 32'(ready_cnt), 32'(NM));
    chk("stop_still_off", 32'(busy), 32'd0);
    chk("stop_no_frame", 32'(frame_start), 32'd0);

    // Restart, then abort with rst during bit 7 (a payload 1 bit).
    enable = 1'b1;
    wait_fs(w);
    chk("restart_gap", 32'(w), 32'd1);
    chk("restart_idle_cnt", 32'(idle_cnt), 32'd3);
    repeat (7 * B) @(negedge clk2x);
    chk("bit7_before_rst", 32'(serial_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_serial_out", 32'(serial_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_idle_cnt", 32'(idle_cnt), 32'd0);
    chk("abort_frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk2x);
    rst = 1'b0;
    wait_fs(w);
    chk("post_rst_gap", 32'(w), 32'd1);
    chk("post_rst_idle_cnt", 32'(idle_cnt), 32'd1);
    capture(idle_bits, 10 * B, got, errs);
    chk("post_rst_frame_bits", got, exp_frame(idle_bits));
    chk("post_rst_frame_cycles", 32'(errs), 32'd0);
    @(negedge clk2x);
    chk("final_serial_out", 32'(serial_out), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
